method_call_arbiter: RTL and testbench
======================================

// Module: method_call_arbiter
// PURPOSE
// - Shares one generated method-call port (xxx_req / xxx_busy / xxx_return) between N_REQ requesters.
// - Round-robin arbitration; sequences the req/busy handshake; captures the return value.
// - Returns the captured value to the granted requester with a one-cycle done pulse.
// - Sits between requester FSMs and a single callee instance, e.g. the test method of a Test0xx block.
// PARAMETERS
// - N_REQ    4      number of requesters (2..16)
// - RET_W    32     width of the callee return value
// - TIMEOUT  10000  cycles allowed from m_req assertion to m_busy falling (used only with the macro)
// PORTS
// - clk       in   1      clock; all logic on posedge
// - reset     in   1      synchronous reset, ACTIVE-LOW
// - req_i     in   N_REQ  per-requester call request; level, held until done_o[i]
// - grant_o   out  N_REQ  one-hot; bit i high from ISSUE entry through DONE
// - done_o    out  N_REQ  one-cycle pulse to the granted requester at call completion
// - ret_o     out  RET_W  return value captured at completion; held until the next capture
// - busy_o    out  1      high in any state except IDLE
// - timeout_o out  1      one-cycle pulse when a call is aborted by the watchdog
// - m_req     out  1      callee request
// - m_busy    in   1      callee busy
// - m_return  in   RET_W  callee return value
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE; grant_o=0, done_o=0, ret_o=0, busy_o=0, timeout_o=0, m_req=0.
// - Round-robin pointer resets to 0.
// - Reset mid-call returns to IDLE in the same cycle. The callee is not aborted; resetting it is the system's job.
// - IDLE: if any req_i bit is set, pick the first set bit at or after ptr, wrapping modulo N_REQ.
//   Latch it into grant_o and go to ISSUE on the next clock.
// - ISSUE: m_req=1. Stay until m_busy==1 is sampled, then go to WAIT and drop m_req.
// - WAIT: m_req=0. When m_busy==0 is sampled: ret_o<=m_return, go to DONE.
// - DONE: done_o[g]=1 for exactly one cycle; ptr<=g+1 (wraps N_REQ-1 -> 0); grant_o<=0; return to IDLE.
// - Minimum call: 1 (IDLE) + 1 (ISSUE) + k busy cycles + 1 (DONE). Back-to-back grants leave one IDLE cycle between them.
// - Only req_i is sampled in IDLE. A requester dropping req_i mid-call does not abort it; done_o still pulses.
// - A request raised while another call is in flight waits. Arbitration happens only in IDLE.
// - Requester g must drop req_i[g] on the done_o cycle, or it re-enters arbitration.
//   It then has lowest priority because ptr has advanced past it.
// - Simultaneous requests: lowest index at or after ptr wins. No requester waits more than N_REQ-1 grants.
// - ret_o is unchanged on timeout.
// CONFIGURATION
// - Macro METHOD_CALL_ARB_TIMEOUT_EN defined:
//   - A 32-bit counter clears on ISSUE entry and increments in ISSUE and WAIT.
//   - If it reaches TIMEOUT: m_req<=0, timeout_o pulses 1 cycle, done_o[g] pulses 1 cycle,
//     ret_o is kept, ptr advances, next state IDLE.
// - Macro not defined: no counter; timeout_o is tied to 0; ISSUE/WAIT wait indefinitely.
// TESTING
// 1. Hold reset low for cycles 3..8 with req_i=4'b1111.
//    -> All outputs 0 throughout; the first grant appears only after reset returns high.
// 2. Single call: req_i=4'b0010; the callee raises busy 1 cycle after m_req and holds it 3 cycles,
//    returning 32'h0000_0001.
//    -> grant_o=4'b0010, m_req high exactly until busy is seen,
//       done_o=4'b0010 for one cycle, ret_o=32'h1.
// 3. Fairness: req_i=4'b1111 held; each requester drops its req on its done.
//    -> Grant order 0,1,2,3; no grant overlaps; one IDLE cycle between consecutive grants.
// 4. Wrap: ptr=3 after a grant to 2, then req_i=4'b1001.
//    -> Requester 3 is granted first, then 0; ptr ends at 1.
// 5. Reset mid-call: pulse reset low for 1 cycle during WAIT.
//    -> Next cycle state IDLE, m_req=0, grant_o=0; no done_o pulse; ret_o=0.
// 6. With METHOD_CALL_ARB_TIMEOUT_EN and TIMEOUT=16, the callee never raises busy.
//    -> timeout_o and done_o[g] pulse together, 16 cycles after ISSUE entry; ret_o unchanged.
//    Without the macro: no pulses; busy_o stays 1.

Source files
------------

// File: rtl/method_call_arbiter.sv
// method_call_arbiter: round-robin sharing of one req/busy/return method-call port between N_REQ requesters.
// Optional watchdog enabled by defining METHOD_CALL_ARB_TIMEOUT_EN (uses the TIMEOUT parameter).
module method_call_arbiter #(
    parameter int N_REQ   = 4,
    parameter int RET_W   = 32,
    parameter int TIMEOUT = 10000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [N_REQ-1:0] done_o,
    output logic [RET_W-1:0] ret_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic             m_req,
    input  logic             m_busy,
    input  logic [RET_W-1:0] m_return
);
    localparam int              PW   = $clog2(N_REQ);
    localparam logic [PW:0]     NR   = (PW+1)'(N_REQ);
    localparam logic [PW-1:0]   LAST = PW'(N_REQ-1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_TOUT} state_t;

    state_t           r_state, w_next;
    logic [N_REQ-1:0] r_grant, w_pick_oh;
    logic [PW-1:0]    r_ptr, r_gidx, w_pick_idx;
    logic [PW:0]      w_sum;
    logic             w_any, w_tout;
    logic [RET_W-1:0] r_ret;

    // Reject out-of-range parameters at elaboration
    if (N_REQ < 2 || N_REQ > 16 || RET_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("method_call_arbiter: parameter out of range");
    end

    // Round-robin pick: scan downward so the lowest offset from r_ptr wins
    always_comb begin
        w_any      = 1'b0;
        w_pick_idx = '0;
        w_sum      = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= NR) w_sum = w_sum - NR;
            if (req_i[w_sum[PW-1:0]]) begin
                w_any      = 1'b1;
                w_pick_idx = w_sum[PW-1:0];
            end
        end
        w_pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
    end

`ifdef METHOD_CALL_ARB_TIMEOUT_EN
    logic [31:0] r_cnt;

    // Watchdog: zero outside a call, so it starts at 0 on ISSUE entry
    always_ff @(posedge clk) begin
        if (!reset) r_cnt <= '0;
        else        r_cnt <= (r_state == S_ISSUE || r_state == S_WAIT) ? r_cnt + 32'd1 : '0;
    end

    assign w_tout = (r_state == S_ISSUE || r_state == S_WAIT) && r_cnt == 32'(TIMEOUT-1);
`else
    assign w_tout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state: a callee completion in WAIT beats a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_any ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = w_tout ? S_TOUT : (m_busy ? S_WAIT : S_ISSUE);
            S_WAIT:  w_next = !m_busy ? S_DONE : (w_tout ? S_TOUT : S_WAIT);
            default: w_next = S_IDLE;
        endcase
    end

    // Grant latch in IDLE, release and pointer advance at call end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else if (r_state == S_IDLE && w_any) begin
            r_grant <= w_pick_oh;
            r_gidx  <= w_pick_idx;
        end else if (r_state == S_DONE || r_state == S_TOUT) begin
            r_grant <= '0;
            r_ptr   <= (r_gidx == LAST) ? '0 : r_gidx + 1'b1;
        end
    end

    // Capture the callee return when busy falls; untouched on timeout
    always_ff @(posedge clk) begin
        if (!reset)                           r_ret <= '0;
        else if (r_state == S_WAIT && !m_busy) r_ret <= m_return;
    end

    // Outputs decoded from state
    always_comb begin
        grant_o   = r_grant;
        done_o    = (r_state == S_DONE || r_state == S_TOUT) ? r_grant : '0;
        ret_o     = r_ret;
        busy_o    = r_state != S_IDLE;
        timeout_o = r_state == S_TOUT;
        m_req     = r_state == S_ISSUE;
    end
endmodule

// File: tb/tb_method_call_arbiter.sv
// tb_method_call_arbiter: directed checks of arbitration order, handshake, reset and watchdog.
module tb_method_call_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_i, grant_o, done_o;
    logic [31:0] ret_o, m_return;
    logic        busy_o, timeout_o, m_req, m_busy;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    method_call_arbiter #(.N_REQ(4), .RET_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .grant_o(grant_o), .done_o(done_o),
        .ret_o(ret_o), .busy_o(busy_o), .timeout_o(timeout_o), .m_req(m_req),
        .m_busy(m_busy), .m_return(m_return)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] quiet();
        return 32'({grant_o, done_o, busy_o, timeout_o, m_req});
    endfunction

    // Entered at the negedge where ISSUE is first visible; leaves at the following IDLE negedge
    task automatic do_call(input string tag, input logic [3:0] g, input logic [31:0] rv,
                           input int d, input int k);
        chk({tag, " grant"}, 32'(grant_o), 32'(g));
        chk({tag, " mreq"}, 32'(m_req), 32'd1);
        chk({tag, " nodone"}, 32'(done_o), 32'd0);
        repeat (d) begin
            @(negedge clk);
            chk({tag, " mreq held"}, 32'(m_req), 32'd1);
        end
        m_busy = 1'b1;
        @(negedge clk);
        chk({tag, " mreq drop"}, 32'(m_req), 32'd0);
        chk({tag, " grant wait"}, 32'(grant_o), 32'(g));
        repeat (k-1) @(negedge clk);
        m_busy   = 1'b0;
        m_return = rv;
        @(negedge clk);
        chk({tag, " done"}, 32'(done_o), 32'(g));
        chk({tag, " ret"}, ret_o, rv);
        chk({tag, " no tout"}, 32'(timeout_o), 32'd0);
        req_i    = req_i & ~g;
        m_return = 32'hDEAD_BEEF;
        @(negedge clk);
        chk({tag, " idle"}, quiet(), 32'd0);
        chk({tag, " ret held"}, ret_o, rv);
    endtask

    initial begin
        reset    = 1'b0;
        req_i    = 4'b1111;
        m_busy   = 1'b0;
        m_return = 32'd0;
        repeat (6) begin
            @(negedge clk);
            chk("rst quiet", quiet(), 32'd0);
            chk("rst ret", ret_o, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        do_call("t1", 4'b0001, 32'h0000_00A5, 0, 1);
        req_i = 4'b0010;
        @(negedge clk);
        do_call("t2", 4'b0010, 32'h0000_0001, 1, 3);
        req_i = 4'b0100;
        @(negedge clk);
        do_call("t4a", 4'b0100, 32'h22, 0, 1);
        req_i = 4'b1001;
        @(negedge clk);
        do_call("t4b", 4'b1000, 32'h33, 0, 2);
        @(negedge clk);
        do_call("t4c", 4'b0001, 32'h44, 0, 1);
        req_i = 4'b0011;
        @(negedge clk);
        do_call("t4d", 4'b0010, 32'h55, 0, 1);
        @(negedge clk);
        do_call("t4e", 4'b0001, 32'h66, 0, 1);
        req_i = 4'b0100;
        @(negedge clk);
        chk("t5 grant", 32'(grant_o), 32'h4);
        m_busy = 1'b1;
        @(negedge clk);
        chk("t5 wait mreq", 32'(m_req), 32'd0);
        chk("t5 wait busy", 32'(busy_o), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5 quiet", quiet(), 32'd0);
        chk("t5 ret", ret_o, 32'd0);
        reset  = 1'b1;
        m_busy = 1'b0;
        req_i  = 4'b0000;
        @(negedge clk);
        chk("t5 no done", quiet(), 32'd0);
        req_i = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            do_call("t3", 4'(1 << g), 32'h100 + 32'(g), 0, 2);
        end
        req_i = 4'b0001;
        @(negedge clk);
        chk("t6 grant", 32'(grant_o), 32'h1);
        chk("t6 mreq", 32'(m_req), 32'd1);
`ifdef METHOD_CALL_ARB_TIMEOUT_EN
        repeat (15) begin
            @(negedge clk);
            chk("t6 pending", 32'({timeout_o, done_o, m_req}), 32'h01);
        end
        @(negedge clk);
        chk("t6 tout", 32'(timeout_o), 32'd1);
        chk("t6 done", 32'(done_o), 32'h1);
        chk("t6 ret", ret_o, 32'h103);
        chk("t6 mreq", 32'(m_req), 32'd0);
        req_i = 4'b0000;
        @(negedge clk);
        chk("t6 idle", quiet(), 32'd0);
        chk("t6 ret held", ret_o, 32'h103);
`else
        repeat (20) begin
            @(negedge clk);
            chk("t6 hang", 32'({timeout_o, done_o, busy_o, m_req}), 32'h03);
        end
        chk("t6 ret", ret_o, 32'h103);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
